// File: rtl/conv_mac_pkg.sv
// Shared types and arithmetic helpers for the conv_mac_unit MAC datapath.
package conv_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Wide enough to hold any accumulator this unit can be configured with.
    localparam int SAT_W = 128;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic logic signed [SAT_W-1:0] round_const(input int frac_bits);
        return SAT_W'(1) <<< (frac_bits - 1);
    endfunction

    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] value,
                                                         input int out_width);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (out_width - 1)) - SAT_W'(1);
        lo = -hi - SAT_W'(1);
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/conv_mac_unit_mult.sv
// One registered signed multiplier lane with its valid bit.
module mac_lane_mult
    import conv_mac_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_valid,
    input  logic signed [DATA_WIDTH-1:0]   i_a,
    input  logic signed [DATA_WIDTH-1:0]   i_b,
    output logic                           o_valid,
    output logic signed [2*DATA_WIDTH-1:0] o_prod
);

    logic                           r_valid;
    logic signed [2*DATA_WIDTH-1:0] r_prod;

    // NOTE: sequential state is always written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_valid <= 1'b0;
        else     r_valid <= i_valid;
    end

    // NOTE: datapath registers carry no reset; only the valid bit decides whether they are consumed.
    always_ff @(posedge clk) begin
        r_prod <= i_a * i_b;
    end

    assign o_valid = r_valid;
    assign o_prod  = r_prod;

endmodule

// File: rtl/conv_mac_unit.sv
// Pipelined multi-lane fixed-point MAC with rounded, saturated output.
// Build option: define CONV_MAC_RELU_EN to clamp negative results to zero.
module conv_mac_unit
    import conv_mac_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int FRACTIONAL_BITS = 8,
    parameter int LANES           = 5,
    parameter int MAX_TAPS        = 32,
    parameter int ACC_WIDTH       = 40
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [clog2(MAX_TAPS+1)-1:0]         cfg_taps,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]          in_data,
    input  logic [LANES*DATA_WIDTH-1:0]          in_weight,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic                                 busy
);

    localparam int CNT_W  = clog2(MAX_TAPS + 1);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int RND_W  = ACC_WIDTH + 1;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_taps;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_taps_eff;
    logic [CNT_W-1:0]       w_count_next;
    logic                   w_accept;
    logic                   w_last;

    assign in_ready     = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
    assign busy         = (r_state != ST_IDLE);
    assign w_accept     = in_valid && in_ready;
    assign w_count_next = r_count + CNT_W'(1);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_taps_eff = cfg_taps;
        if (cfg_taps == '0)                     w_taps_eff = CNT_W'(1);
        else if (cfg_taps > CNT_W'(MAX_TAPS))   w_taps_eff = CNT_W'(MAX_TAPS);
    end

    assign w_last = (r_state == ST_IDLE) ? (w_taps_eff == CNT_W'(1)) : (w_count_next == r_taps);

    logic                       r_s1_first, r_s1_last;
    logic                       r_s2_valid, r_s2_first, r_s2_last;
    logic                       r_s3_valid, r_s3_last;
    logic [LANES-1:0]           w_lane_valid;
    logic                       w_s1_valid;
    logic signed [PROD_W-1:0]   w_prod [LANES];
    logic signed [ACC_WIDTH-1:0] w_lane_sum;
    logic signed [ACC_WIDTH-1:0] r_s2_sum;
    logic signed [ACC_WIDTH-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_taps  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_taps  <= w_taps_eff;
                    r_count <= CNT_W'(1);
                    r_state <= w_last ? ST_DRAIN : ST_ACCUM;
                end
                ST_ACCUM: if (w_accept) begin
                    r_count <= w_count_next;
                    if (w_last) r_state <= ST_DRAIN;
                end
                ST_DRAIN: if (r_s3_valid && r_s3_last) r_state <= ST_DONE;
                ST_DONE:  if (out_ready) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            mac_lane_mult #(.DATA_WIDTH(DATA_WIDTH)) u_mult (
                .clk     (clk),
                .rst     (rst),
                .i_valid (w_accept),
                .i_a     (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
                .i_b     (in_weight[g*DATA_WIDTH +: DATA_WIDTH]),
                .o_valid (w_lane_valid[g]),
                .o_prod  (w_prod[g])
            );
        end
    endgenerate

    assign w_s1_valid = &w_lane_valid;

    // Lane products are sign-extended to the accumulator width before summing, so nothing is truncated.
    always_comb begin
        w_lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_sum = w_lane_sum + ACC_WIDTH'(w_prod[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s3_last  <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_s1_first <= w_accept && (r_state == ST_IDLE);
            r_s1_last  <= w_accept && w_last;
            r_s2_valid <= w_s1_valid;
            r_s2_first <= w_s1_valid && r_s1_first;
            r_s2_last  <= w_s1_valid && r_s1_last;
            r_s3_valid <= r_s2_valid;
            r_s3_last  <= r_s2_valid && r_s2_last;
            if (r_s2_valid) r_acc <= r_s2_first ? r_s2_sum : r_acc + r_s2_sum;
        end
    end

    always_ff @(posedge clk) begin
        r_s2_sum <= w_lane_sum;
    end

    logic signed [RND_W-1:0]      w_rounded;
    logic signed [RND_W-1:0]      w_shifted;
    logic signed [DATA_WIDTH-1:0] w_sat;
    logic [DATA_WIDTH-1:0]        w_result;
    logic                         r_out_valid;
    logic [DATA_WIDTH-1:0]        r_out_data;

    assign w_rounded = RND_W'(r_acc) + RND_W'(round_const(FRACTIONAL_BITS));
    assign w_shifted = w_rounded >>> FRACTIONAL_BITS;
    assign w_sat     = DATA_WIDTH'(saturate(SAT_W'(w_shifted), DATA_WIDTH));

`ifdef CONV_MAC_RELU_EN
    assign w_result = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
`else
    assign w_result = w_sat;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (r_s3_valid && r_s3_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_conv_mac_unit.sv
// Directed, table-driven bench for conv_mac_unit (default Q8.8 configuration).
module tb_conv_mac_unit;

    localparam int DW       = 16;
    localparam int LANES    = 5;
    localparam int MAX_TAPS = 32;
    localparam int CNT_W    = 6;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [CNT_W-1:0]      cfg_taps = '0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [LANES*DW-1:0]   in_data = '0;
    logic [LANES*DW-1:0]   in_weight = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [DW-1:0]         out_data;
    logic                  busy;

    always #5 clk = ~clk;

    conv_mac_unit #(
        .DATA_WIDTH(DW), .FRACTIONAL_BITS(8), .LANES(LANES), .MAX_TAPS(MAX_TAPS), .ACC_WIDTH(40)
    ) dut (
        .clk(clk), .rst(rst), .cfg_taps(cfg_taps), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    typedef struct {
        string       name;
        int          cfg;
        int          beats;
        logic [15:0] d0, w0, dr, wr;
        logic [15:0] exp;
        int          hold;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef CONV_MAC_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    task automatic set_lanes(input logic [15:0] d0, input logic [15:0] w0,
                             input logic [15:0] dr, input logic [15:0] wr);
        for (int i = 0; i < LANES; i++) begin
            in_data[i*DW +: DW]   = (i == 0) ? d0 : dr;
            in_weight[i*DW +: DW] = (i == 0) ? w0 : wr;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        logic [15:0] exp;
        exp = relu(v.exp);
        for (int b = 0; b < v.beats; b++) begin
            @(negedge clk);
            cfg_taps = (b == 0) ? CNT_W'(v.cfg) : CNT_W'(7);
            in_valid = 1'b1;
            set_lanes(v.d0, v.w0, v.dr, v.wr);
            if (b == 0 || b == v.beats - 1)
                check($sformatf("%s in_ready beat%0d", v.name, b), in_ready, 1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check($sformatf("%s drain in_ready", v.name), in_ready, 0);
        check($sformatf("%s drain busy", v.name), busy, 1);
        lat = 1;
        while (lat < 12) begin
            if (out_valid) break;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check($sformatf("%s latency", v.name), lat, 4);
        check($sformatf("%s out_data", v.name), out_data, exp);
        for (int h = 0; h < v.hold; h++) begin
            in_valid = 1'b1;
            set_lanes(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s hold%0d out_valid", v.name, h), out_valid, 1);
            check($sformatf("%s hold%0d out_data", v.name, h), out_data, exp);
            check($sformatf("%s hold%0d in_ready", v.name, h), in_ready, 0);
            check($sformatf("%s hold%0d busy", v.name, h), busy, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check($sformatf("%s released out_valid", v.name), out_valid, 0);
        check($sformatf("%s idle in_ready", v.name), in_ready, 1);
        check($sformatf("%s idle busy", v.name), busy, 0);
    endtask

    initial begin
        int seen;
        vec_t fresh;

        vecs[0] = '{"unity",       1,  1, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0500, 0};
        vecs[1] = '{"negative",    2,  2, 16'h0100, 16'hFF00, 16'h0100, 16'hFF00, 16'hF600, 0};
        vecs[2] = '{"round_up",    1,  1, 16'h0001, 16'h0080, 16'h0000, 16'h0000, 16'h0001, 0};
        vecs[3] = '{"round_neg",   1,  1, 16'hFFFF, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 0};
        vecs[4] = '{"sat_pos",     4,  4, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0};
        vecs[5] = '{"sat_neg",     4,  4, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 0};
        vecs[6] = '{"mixed",       1,  1, 16'h0180, 16'hFE80, 16'h0040, 16'h0400, 16'h01C0, 0};
        vecs[7] = '{"backpress",   3,  3, 16'h0200, 16'h0080, 16'h0000, 16'h0000, 16'h0300, 6};
        vecs[8] = '{"taps_zero",   0,  1, 16'h0100, 16'h0100, 16'h0100, 16'h0040, 16'h0200, 0};
        vecs[9] = '{"taps_clamp", 40, 32, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h2000, 0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset in_ready", in_ready, 1);
        check("reset busy", busy, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 16'h0000);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Abort a 5-tap accumulation after two beats with the beats still in the pipe.
        @(negedge clk);
        cfg_taps = CNT_W'(5);
        in_valid = 1'b1;
        set_lanes(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", busy, 0);
        check("abort in_ready", in_ready, 1);
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort no output", seen, 0);
        fresh = '{"fresh", 1, 1, 16'h0100, 16'h0280, 16'h0000, 16'h0000, 16'h0280, 0};
        run_vec(fresh);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
